thread_cmd_requester: RTL

- CPU-side initiator for the thread-control protocol served by the threads manager.
- Accepts fork (RUN), stop (STOP) and next-thread (GET_NEXT_STATE) requests from the CPU core.
- Obtains the shared command bus and drives thrd_cmd/addr/data. Samples the manager's result and retries rejected commands with back-off.
- Returns one response per request to the core; one instance sits in each CPU.

---
 rtl/thread_cmd_requester_if.sv | 43 ++++
 rtl/thread_cmd_requester.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/thread_cmd_requester_if.sv
// Core request/response and shared thread-command bus signals of one requester.
// master = the requester, slave = core + bus arbiter + threads manager.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

interface thread_cmd_requester_if;
    logic                  req_valid;
    logic [1:0]            req_op;
    logic [`ADDR_SIZE-1:0] req_pc;
    logic [`DATA_SIZE-1:0] req_arg;
    logic                  req_ready;
    logic                  bus_req;
    logic                  bus_grant;
    logic [7:0]            ctl_state;
    logic [3:0]            thrd_cmd;
    logic [`ADDR_SIZE-1:0] addr_out;
    logic [`DATA_SIZE-1:0] data_out;
    logic [1:0]            thrd_rslt;
    logic [`DATA_SIZE-1:0] data_in;
    logic [`ADDR_SIZE-1:0] next_proc_in;
    logic                  rsp_valid;
    logic                  rsp_ok;
    logic [2:0]            rsp_tries;
    logic [`ADDR_SIZE-1:0] next_proc;
    logic [`DATA_SIZE-1:0] next_arg;

    modport master (
        input  req_valid, req_op, req_pc, req_arg, bus_grant, ctl_state,
               thrd_rslt, data_in, next_proc_in,
        output req_ready, bus_req, thrd_cmd, addr_out, data_out,
               rsp_valid, rsp_ok, rsp_tries, next_proc, next_arg
    );
    modport slave (
        output req_valid, req_op, req_pc, req_arg, bus_grant, ctl_state,
               thrd_rslt, data_in, next_proc_in,
        input  req_ready, bus_req, thrd_cmd, addr_out, data_out,
               rsp_valid, rsp_ok, rsp_tries, next_proc, next_arg
    );
endinterface

// File: rtl/thread_cmd_requester.sv
// CPU-side thread-control initiator: issues RUN/STOP over the shared command bus
// with bounded retry + back-off, and fetches the next scheduled thread.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef THREAD_CMD_RUN
`define THREAD_CMD_RUN 4'd1
`endif
`ifndef THREAD_CMD_STOP
`define THREAD_CMD_STOP 4'd2
`endif
`ifndef THREAD_CMD_GET_NEXT_STATE
`define THREAD_CMD_GET_NEXT_STATE 4'd3
`endif
`ifndef CTL_CPU_LOOP
`define CTL_CPU_LOOP 8'h01
`endif
`ifndef CTL_CPU_CMD
`define CTL_CPU_CMD 8'h02
`endif

module thread_cmd_requester #(
    parameter int MAX_RETRY   = 3,   // at most 6: attempts counter is 3 bits
    parameter int BACKOFF_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_oe,
    thread_cmd_requester_if.master io
);
    localparam int BO_W = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
    localparam logic [1:0] OP_STOP = 2'd1;
    localparam logic [1:0] OP_NEXT = 2'd2;
    localparam logic [1:0] OP_RSVD = 2'd3;

    typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, BACKOFF, NWAIT, NCAP} state_t;

    typedef struct packed {
        logic [1:0]            op;
        logic [`ADDR_SIZE-1:0] pc;
        logic [`DATA_SIZE-1:0] arg;
    } req_t;

    state_t          state;
    req_t            cur;
    logic [2:0]      attempts;
    logic [BO_W-1:0] bo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            attempts     <= '0;
            bo_cnt       <= '0;
            io.req_ready <= 1'b1;
            io.bus_req   <= 1'b0;
            io.thrd_cmd  <= '0;
            io.addr_out  <= '0;
            io.data_out  <= '0;
            io.rsp_valid <= 1'b0;
            io.rsp_ok    <= 1'b0;
            io.rsp_tries <= '0;
            io.next_proc <= '0;
            io.next_arg  <= '0;
        end else if (clk_oe) begin
            io.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.req_valid && io.req_ready) begin
                        if (io.req_op == OP_RSVD) begin
                            io.rsp_valid <= 1'b1;
                            io.rsp_ok    <= 1'b0;
                            io.rsp_tries <= '0;
                        end else begin
                            cur          <= '{op: io.req_op, pc: io.req_pc, arg: io.req_arg};
                            attempts     <= 3'd1;
                            io.req_ready <= 1'b0;
                            if (io.req_op == OP_NEXT) begin
                                io.thrd_cmd <= `THREAD_CMD_GET_NEXT_STATE;
                                state       <= NWAIT;
                            end else begin
                                io.bus_req <= 1'b1;
                                state      <= REQ;
                            end
                        end
                    end
                end
                // Grant alone is not enough: the manager only listens in CPU_CMD.
                REQ: begin
                    if (io.bus_grant && io.ctl_state == `CTL_CPU_CMD) begin
                        io.thrd_cmd <= (cur.op == OP_STOP) ? `THREAD_CMD_STOP : `THREAD_CMD_RUN;
                        io.addr_out <= cur.pc;
                        io.data_out <= cur.arg;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    io.thrd_cmd <= '0;
                    io.addr_out <= '0;
                    io.data_out <= '0;
                    io.bus_req  <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (io.thrd_rslt == 2'd1 && (&io.data_in)) begin
                        io.rsp_valid <= 1'b1;
                        io.rsp_ok    <= 1'b1;
                        io.rsp_tries <= attempts;
                        io.req_ready <= 1'b1;
                        state        <= IDLE;
                    end else if (attempts == 3'(MAX_RETRY + 1)) begin
                        io.rsp_valid <= 1'b1;
                        io.rsp_ok    <= 1'b0;
                        io.rsp_tries <= attempts;
                        io.req_ready <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        attempts <= attempts + 3'd1;
                        bo_cnt   <= '0;
                        if (BACKOFF_CYC == 0) begin
                            io.bus_req <= 1'b1;
                            state      <= REQ;
                        end else begin
                            state <= BACKOFF;
                        end
                    end
                end
                BACKOFF: begin
                    if (bo_cnt == BO_W'(BACKOFF_CYC - 1)) begin
                        io.bus_req <= 1'b1;
                        state      <= REQ;
                    end else begin
                        bo_cnt <= bo_cnt + 1'b1;
                    end
                end
                // GET_NEXT_STATE is a single-cycle strobe, dropped here regardless of exit.
                NWAIT: begin
                    io.thrd_cmd <= '0;
                    if (io.ctl_state == `CTL_CPU_LOOP)
                        state <= NCAP;
                end
                NCAP: begin
                    io.next_proc <= io.next_proc_in;
                    io.next_arg  <= io.data_in;
                    io.rsp_valid <= 1'b1;
                    io.rsp_ok    <= 1'b1;
                    io.rsp_tries <= 3'd1;
                    io.req_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
